// File: rtl/mem_scan_pkg.sv
// Shared types and constants for the memory scan display.
// The scan FSM state encoding and the hex-to-seven-segment lookup table.
package mem_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_SHOW = 2'd3
    } scan_state_e;

    // Segments a..g with bit0 = a. Entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational 4-bit hex to 7-segment decoder (active-high, bit0 = a),
// driven from the shared package table.
module hex_to_seg7
    import mem_scan_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG7_TABLE[hex_i];

endmodule

// File: rtl/mem_scan_display.sv
// Sweeps every memory address, reads it and shows the value on SEG.
// Optional build macro MEM_SCAN_COUNT_EN adds the scan_count sweep counter.
//
// state | meaning
// IDLE  | scanning disabled, display blank
// REQ   | one-cycle read request for the current address
// WAIT  | memory data arrives; captured into the display at cycle end
// SHOW  | dwell on the captured digit for HOLD_CYCLES cycles
module mem_scan_display
    import mem_scan_pkg::*;
#(
    parameter int ADDR_WIDTH  = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                  clk_2,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  freeze,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [3:0]            rd_data,
    output logic [7:0]            SEG,
    output logic [ADDR_WIDTH-1:0] disp_addr,
`ifdef MEM_SCAN_COUNT_EN
    output logic [7:0]            scan_count,
`endif
    output logic                  disp_valid
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
    localparam logic [7:0]            HOLD_M1   = 8'(HOLD_CYCLES - 1);

    scan_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            dwell_q, dwell_d;
    logic [7:0]            seg_q, seg_d;
    logic [ADDR_WIDTH-1:0] disp_addr_q, disp_addr_d;
    logic                  valid_q, valid_d;
    logic                  rd_en_q;
    logic [6:0]            seg_code;
    logic                  advance;

    hex_to_seg7 u_dec (
        .hex_i (rd_data),
        .seg_o (seg_code)
    );

    assign advance = enable && (state_q == ST_SHOW) && (dwell_q == 8'd0) && !freeze;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        dwell_d     = dwell_q;
        seg_d       = seg_q;
        disp_addr_d = disp_addr_q;
        valid_d     = valid_q;
        if (!enable) begin
            // Address counter is kept so re-enabling resumes where it stopped.
            state_d = ST_IDLE;
            seg_d   = 8'h00;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_REQ;
                ST_REQ:  state_d = ST_WAIT;
                ST_WAIT: begin
                    seg_d       = {(addr_q == LAST_ADDR), seg_code};
                    disp_addr_d = addr_q;
                    valid_d     = 1'b1;
                    dwell_d     = HOLD_M1;
                    state_d     = ST_SHOW;
                end
                default: begin
                    if (dwell_q == 8'd0) begin
                        state_d = ST_REQ;
                        if (advance) addr_d = addr_q + ADDR_WIDTH'(1);
                    end else begin
                        dwell_d = dwell_q - 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            dwell_q     <= 8'd0;
            seg_q       <= 8'h00;
            disp_addr_q <= '0;
            valid_q     <= 1'b0;
            rd_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            dwell_q     <= dwell_d;
            seg_q       <= seg_d;
            disp_addr_q <= disp_addr_d;
            valid_q     <= valid_d;
            rd_en_q     <= (state_d == ST_REQ);
        end
    end

`ifdef MEM_SCAN_COUNT_EN
    logic [7:0] sweep_q;

    // Counts completed sweeps; a frozen re-read never counts, enable=0 never clears.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            sweep_q <= 8'd0;
        end else if (advance && (addr_q == LAST_ADDR)) begin
            sweep_q <= sweep_q + 8'd1;
        end
    end

    assign scan_count = sweep_q;
`endif

    assign rd_en      = rd_en_q;
    assign rd_addr    = addr_q;
    assign SEG        = seg_q;
    assign disp_addr  = disp_addr_q;
    assign disp_valid = valid_q;

endmodule

// File: tb/tb_mem_scan_display.sv
// Self-checking bench for mem_scan_display: per-cycle vector table for the
// first sweep plus directed freeze / enable-drop / reset / HOLD_CYCLES=1 cases.
module tb_mem_scan_display;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       freeze = 1'b0;
    logic       rd_en;
    logic [1:0] rd_addr;
    logic [3:0] rd_data = 4'h0;
    logic [7:0] seg;
    logic [1:0] disp_addr;
    logic       disp_valid;

    logic       en1 = 1'b0;
    logic       rd_en1;
    logic [1:0] rd_addr1;
    logic [3:0] rd_data1 = 4'h0;
    logic [7:0] seg1;
    logic [1:0] disp_addr1;
    logic       disp_valid1;

`ifdef MEM_SCAN_COUNT_EN
    logic [7:0] scan_count;
    logic [7:0] scan_count1;
`endif

    logic [3:0] mem0 [4];
    logic [3:0] mem1 [4];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_scan_display #(.ADDR_WIDTH(2), .HOLD_CYCLES(4)) dut (
        .clk_2      (clk),
        .reset_n    (reset_n),
        .enable     (enable),
        .freeze     (freeze),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .SEG        (seg),
        .disp_addr  (disp_addr),
`ifdef MEM_SCAN_COUNT_EN
        .scan_count (scan_count),
`endif
        .disp_valid (disp_valid)
    );

    mem_scan_display #(.ADDR_WIDTH(2), .HOLD_CYCLES(1)) dut1 (
        .clk_2      (clk),
        .reset_n    (reset_n),
        .enable     (en1),
        .freeze     (1'b0),
        .rd_en      (rd_en1),
        .rd_addr    (rd_addr1),
        .rd_data    (rd_data1),
        .SEG        (seg1),
        .disp_addr  (disp_addr1),
`ifdef MEM_SCAN_COUNT_EN
        .scan_count (scan_count1),
`endif
        .disp_valid (disp_valid1)
    );

    // Registered-read memories: data valid the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en)  rd_data  <= mem0[rd_addr];
        if (rd_en1) rd_data1 <= mem1[rd_addr1];
    end

    typedef struct {
        logic       rd_en;
        logic [1:0] addr;
        logic [7:0] seg;
        logic       valid;
        logic [1:0] daddr;
    } vec_t;

    localparam int NVEC = 31;
    vec_t vecs [NVEC];

    task automatic set_rng(input int lo, input int hi, input logic en, input logic [1:0] a,
                           input logic [7:0] s, input logic v, input logic [1:0] d);
        for (int i = lo; i <= hi; i++) begin
            vecs[i].rd_en = en;
            vecs[i].addr  = a;
            vecs[i].seg   = s;
            vecs[i].valid = v;
            vecs[i].daddr = d;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_req(input logic [1:0] exp, input string nm);
        int n = 0;
        @(negedge clk);
        while (!rd_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!rd_en) begin
            failures++;
            $display("FAIL %s: no read request within 20 cycles, expected addr %0d", nm, exp);
        end else if (rd_addr !== exp) begin
            failures++;
            $display("FAIL %s: rd_addr got %0d expected %0d", nm, rd_addr, exp);
        end
    endtask

    logic [7:0] seg_tbl [4];

    initial begin
        mem0[0] = 4'h3; mem0[1] = 4'h5; mem0[2] = 4'hA; mem0[3] = 4'hF;
        mem1[0] = 4'h3; mem1[1] = 4'h5; mem1[2] = 4'hA; mem1[3] = 4'hF;
        seg_tbl[0] = 8'h4F; seg_tbl[1] = 8'h6D; seg_tbl[2] = 8'h77; seg_tbl[3] = 8'hF1;

        set_rng(0,  0,  1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        set_rng(1,  1,  1'b1, 2'd0, 8'h00, 1'b0, 2'd0);
        set_rng(2,  2,  1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
        set_rng(3,  6,  1'b0, 2'd0, 8'h4F, 1'b1, 2'd0);
        set_rng(7,  7,  1'b1, 2'd1, 8'h4F, 1'b1, 2'd0);
        set_rng(8,  8,  1'b0, 2'd1, 8'h4F, 1'b1, 2'd0);
        set_rng(9,  12, 1'b0, 2'd1, 8'h6D, 1'b1, 2'd1);
        set_rng(13, 13, 1'b1, 2'd2, 8'h6D, 1'b1, 2'd1);
        set_rng(14, 14, 1'b0, 2'd2, 8'h6D, 1'b1, 2'd1);
        set_rng(15, 18, 1'b0, 2'd2, 8'h77, 1'b1, 2'd2);
        set_rng(19, 19, 1'b1, 2'd3, 8'h77, 1'b1, 2'd2);
        set_rng(20, 20, 1'b0, 2'd3, 8'h77, 1'b1, 2'd2);
        set_rng(21, 24, 1'b0, 2'd3, 8'hF1, 1'b1, 2'd3);
        set_rng(25, 25, 1'b1, 2'd0, 8'hF1, 1'b1, 2'd3);
        set_rng(26, 26, 1'b0, 2'd0, 8'hF1, 1'b1, 2'd3);
        set_rng(27, 30, 1'b0, 2'd0, 8'h4F, 1'b1, 2'd0);

        repeat (3) @(negedge clk);
        chk("reset rd_en", {31'd0, rd_en}, 32'd0);
        chk("reset SEG", {24'd0, seg}, 32'h00);
        chk("reset disp", {29'd0, disp_valid, disp_addr}, 32'd0);
        reset_n = 1'b1;

        // Cycle 0 is the cycle in which enable goes high.
        @(posedge clk); #1;
        enable = 1'b1;
        for (int k = 0; k < NVEC; k++) begin
            @(negedge clk);
            checks++;
            if (rd_en !== vecs[k].rd_en || seg !== vecs[k].seg || disp_valid !== vecs[k].valid ||
                (vecs[k].rd_en && rd_addr !== vecs[k].addr) ||
                (vecs[k].valid && disp_addr !== vecs[k].daddr)) begin
                failures++;
                $display("FAIL sweep cycle %0d: rd_en=%0b rd_addr=%0d SEG=%02h valid=%0b daddr=%0d expected rd_en=%0b rd_addr=%0d SEG=%02h valid=%0b daddr=%0d",
                         k, rd_en, rd_addr, seg, disp_valid, disp_addr,
                         vecs[k].rd_en, vecs[k].addr, vecs[k].seg, vecs[k].valid, vecs[k].daddr);
            end
        end
`ifdef MEM_SCAN_COUNT_EN
        chk("scan_count after first wrap", {24'd0, scan_count}, 32'd1);
`endif

        // Freeze on address 2, live write shows up on the re-read.
        wait_req(2'd1, "req addr1");
        wait_req(2'd2, "req addr2");
        freeze = 1'b1;
        repeat (2) @(negedge clk);
        chk("SEG addr2 before write", {24'd0, seg}, 32'h77);
        mem0[2] = 4'h1;
        wait_req(2'd2, "frozen re-read addr");
        repeat (2) @(negedge clk);
        chk("SEG after live write", {24'd0, seg}, 32'h06);
        chk("disp_addr frozen", {30'd0, disp_addr}, 32'd2);
        freeze = 1'b0;
        wait_req(2'd3, "resume after freeze");
        chk("SEG held in REQ", {24'd0, seg}, 32'h06);

        // Drop enable during WAIT.
        @(negedge clk);
        chk("SEG held in WAIT", {23'd0, disp_valid, seg}, 32'h106);
        enable = 1'b0;
        @(negedge clk);
        chk("idle after enable drop", {22'd0, rd_en, disp_valid, seg}, 32'h000);
        enable = 1'b1;
        wait_req(2'd3, "re-enable same addr");
        repeat (2) @(negedge clk);
        chk("SEG addr3 dp", {24'd0, seg}, 32'hF1);
`ifdef MEM_SCAN_COUNT_EN
        chk("scan_count no wrap yet", {24'd0, scan_count}, 32'd1);
`endif
        wait_req(2'd0, "wrap to addr0");
`ifdef MEM_SCAN_COUNT_EN
        chk("scan_count second wrap", {24'd0, scan_count}, 32'd2);
`endif
        wait_req(2'd1, "pre-reset addr1");
        wait_req(2'd2, "pre-reset addr2");
        repeat (2) @(negedge clk);
        chk("SEG addr2 before reset", {24'd0, seg}, 32'h06);

        // Asynchronous reset in SHOW.
        reset_n = 1'b0;
        #1;
        chk("async reset outputs", {18'd0, rd_en, rd_addr, seg, disp_valid, disp_addr}, 32'd0);
`ifdef MEM_SCAN_COUNT_EN
        chk("async reset scan_count", {24'd0, scan_count}, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        wait_req(2'd0, "first req after reset");

        // HOLD_CYCLES = 1: period of 3 cycles, never back-to-back rd_en.
        en1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("hold1 rd_en c%0d", i), {31'd0, rd_en1}, {31'd0, (i % 3) == 0});
            if ((i % 3) == 0)
                chk($sformatf("hold1 rd_addr c%0d", i), {30'd0, rd_addr1}, (i / 3) % 4);
            if ((i % 3) == 2)
                chk($sformatf("hold1 SEG c%0d", i), {24'd0, seg1}, {24'd0, seg_tbl[(i / 3) % 4]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
